// File: rtl/enc16to4_seq.sv
// enc16to4_seq: sequential 16-to-4 encoder.
// A 16-bit request vector is captured in IDLE and then emitted as one 4-bit
// index per valid/ready transfer until every set bit has been sent.
// Optional feature: define ROUND_ROBIN_EN to replace fixed lowest-index
// priority with a round-robin pointer that persists across batches.
//
// Handshake: valid/ready. A transfer happens on the rising edge where
// valid=1 and ready=1. Once valid rises it stays high, with y held stable,
// until that transfer. valid does not depend combinationally on ready.
// FSM state is observable on busy (busy=1 exactly when the FSM is in BUSY).
module enc16to4_seq #(
  parameter int N_IN   = 16,
  parameter int CODE_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [0:N_IN-1]   w,
  input  logic              en,
  input  logic              ready,
  output logic [CODE_W-1:0] y,
  output logic              valid,
  output logic              busy,
  output logic [CNT_W-1:0]  pend_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [N_IN-1:0]     r_pend;
  logic [CNT_W-1:0]    r_cnt;
  logic [CODE_W-1:0]   r_y;
  logic                r_valid;
  logic                r_busy;

  logic [N_IN-1:0]     w_req;
  logic [CNT_W-1:0]    w_req_cnt;
  logic [N_IN-1:0]     w_pend_left;
  logic [CODE_W-1:0]   w_sel_cap;
  logic [CODE_W-1:0]   w_sel_next;
  logic                w_xfer;

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0]   r_rr;
  logic [CODE_W-1:0]   w_rr_next;

  // First set bit of v scanning upward from start, wrapping past 15 to 0.
  function automatic logic [CODE_W-1:0] pick_rr(input logic [N_IN-1:0] v,
                                                input logic [CODE_W-1:0] start);
    logic [CODE_W-1:0] s;
    logic [CODE_W-1:0] idx;
    s = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = start + CODE_W'(k);
      if (v[idx]) s = idx;
    end
    return s;
  endfunction
`else
  // Lowest set index of v; bit 0 has the highest priority.
  function automatic logic [CODE_W-1:0] pick_low(input logic [N_IN-1:0] v);
    logic [CODE_W-1:0] s;
    s = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (v[k]) s = CODE_W'(k);
    end
    return s;
  endfunction
`endif

  // Request remap, popcount, and next-index selection for capture and transfer.
  always_comb begin
    w_req     = '0;
    w_req_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_req[i]  = w[i];
      w_req_cnt = w_req_cnt + CNT_W'(w[i]);
    end
    w_pend_left = r_pend & ~(N_IN'(1) << r_y);
    w_xfer      = r_valid & ready;
`ifdef ROUND_ROBIN_EN
    w_rr_next  = r_y + CODE_W'(1);
    w_sel_cap  = pick_rr(w_req, r_rr);
    w_sel_next = pick_rr(w_pend_left, w_rr_next);
`else
    w_sel_cap  = pick_low(w_req);
    w_sel_next = pick_low(w_pend_left);
`endif
  end

  // Control FSM with registered outputs; reset discards any pending batch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_rr    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && (w_req != '0)) begin
            r_pend  <= w_req;
            r_cnt   <= w_req_cnt;
            r_y     <= w_sel_cap;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // en and w are deliberately ignored here; nothing is queued.
          if (w_xfer) begin
`ifdef ROUND_ROBIN_EN
            r_rr <= w_rr_next;
`endif
            if (r_cnt == CNT_W'(1)) begin
              r_pend  <= '0;
              r_cnt   <= '0;
              r_y     <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_pend <= w_pend_left;
              r_cnt  <= r_cnt - CNT_W'(1);
              r_y    <= w_sel_next;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign y        = r_y;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign pend_cnt = r_cnt;

endmodule

// File: tb/tb_enc16to4_seq.sv
// Self-checking bench for enc16to4_seq: directed batches, expected codes in a
// queue, backpressure, mid-batch reset, ignored capture while busy.
module tb_enc16to4_seq;

  localparam int W = 4;

  logic         clk;
  logic         resetn;
  logic [0:15]  w;
  logic         en;
  logic         ready;
  logic [3:0]   y;
  logic         valid;
  logic         busy;
  logic [4:0]   pend_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;

  logic [W-1:0] exp_q[$];

  enc16to4_seq dut (
    .clk      (clk),
    .resetn   (resetn),
    .w        (w),
    .en       (en),
    .ready    (ready),
    .y        (y),
    .valid    (valid),
    .busy     (busy),
    .pend_cnt (pend_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Converts a vector written MSB=bit15 into the w[0:15] port so that w[i]
  // carries request index i.
  task automatic set_w(input logic [15:0] v);
    for (int i = 0; i < 16; i++) w[i] = v[i];
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    en     = 1'b0;
    ready  = 1'b0;
    set_w(16'h0000);
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // Pulse en with a request vector for one edge; outputs checked after it.
  task automatic capture(input logic [15:0] v);
    set_w(v);
    en = 1'b1;
    step();
    en = 1'b0;
    set_w(16'h0000);
  endtask

  // Hold ready low for 'stall' cycles (y must stay put), then drain exp_q.
  task automatic drain(input int stall, input int max_cyc);
    int cyc;
    logic [W-1:0] e;
    cyc = 0;
    ready = 1'b0;
    while (stall > 0 && exp_q.size() > 0) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_y", 32'(y), 32'(exp_q[0]));
      step();
      stall--;
    end
    ready = 1'b1;
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      if (valid) begin
        e = exp_q.pop_front();
        check("code", 32'(y), 32'(e));
        check("pend_cnt", 32'(pend_cnt), 32'(exp_q.size() + 1));
        n_xfer++;
      end else begin
        check("valid_dropped", 32'(valid), 32'd1);
      end
      step();
      cyc++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    ready = 1'b0;
    check("end_valid", 32'(valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_cnt", 32'(pend_cnt), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b0;
    ready  = 1'b0;
    set_w(16'h0000);
    #2;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(pend_cnt), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // T1: reset asserted mid-batch clears state asynchronously
    capture(16'h00F0);
    check("t1_cnt", 32'(pend_cnt), 32'd4);
    check("t1_y", 32'(y), 32'd4);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("t1_y2", 32'(y), 32'd5);
    check("t1_cnt2", 32'(pend_cnt), 32'd3);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("t1_async_valid", 32'(valid), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    check("t1_async_cnt", 32'(pend_cnt), 32'd0);
    check("t1_async_y", 32'(y), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_no_stale", 32'(valid), 32'd0);
    end
    ready = 1'b0;

    // T2: single request
    capture(16'h0400);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_cnt", 32'(pend_cnt), 32'd1);
    exp_q.push_back(4'd10);
    n_xfer = 0;
    drain(0, 8);
    check("t2_xfers", 32'(n_xfer), 32'd1);

    // T3: multi-hot with three cycles of backpressure
    do_reset();
    capture(16'h8005);
    check("t3_cnt", 32'(pend_cnt), 32'd3);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd15);
    n_xfer = 0;
    drain(3, 12);
    check("t3_xfers", 32'(n_xfer), 32'd3);

    // T4: full vector, en pulsed while busy must be ignored
    do_reset();
    capture(16'hFFFF);
    check("t4_cnt", 32'(pend_cnt), 32'd16);
    capture(16'h0001);
    check("t4_ign_cnt", 32'(pend_cnt), 32'd16);
    check("t4_ign_y", 32'(y), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(W'(i));
    n_xfer = 0;
    drain(0, 40);
    check("t4_xfers", 32'(n_xfer), 32'd16);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_queued", 32'(valid), 32'd0);
    end
    ready = 1'b0;

    // T5: zero request vector stays idle
    capture(16'h0000);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cnt", 32'(pend_cnt), 32'd0);

    // T6: selection order across consecutive batches
    do_reset();
    capture(16'h0002);
    exp_q.push_back(4'd1);
    drain(0, 8);
    capture(16'h0003);
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
`else
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
`endif
    drain(0, 8);
    capture(16'h0005);
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd0);
`else
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd2);
`endif
    drain(1, 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
